// File: rtl/sprite_table_writer.sv
// sprite_table_writer: shadow sprite table plus an Avalon-MM initiator that
// uploads changed entries to the VPU sprite visibility checker once per frame.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   host_we/index/id/x/y  shadow table write port (id 0 = disabled sprite)
//   cfg_offset_x/y      world offsets, sampled at frame_start
//   cfg_world_type      00 = 9x1, 01 = 1x9, 10 = 3x3, 11 = illegal
//   frame_start         vblank pulse that starts an upload
//   err_clear           clears the sticky range_err flag
//   m_write, m_address, m_writedata, m_waitrequest   Avalon-MM initiator
//   busy                upload in progress
//   done                one-cycle pulse after the commit write is accepted
//   frame_skip          one-cycle pulse when frame_start arrives while busy
//   range_err           sticky: a coordinate did not fit its field
//
// With SPRITE_WRITER_FULL_REFRESH_EN, all slots are resent each frame
// and no dirty tracking exists.

module sprite_table_writer #(
    parameter int SPRITE_COUNT = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        host_we,
    input  logic [4:0]  host_index,
    input  logic [8:0]  host_id,
    input  logic [12:0] host_x,
    input  logic [12:0] host_y,
    input  logic [12:0] cfg_offset_x,
    input  logic [12:0] cfg_offset_y,
    input  logic [1:0]  cfg_world_type,
    input  logic        frame_start,
    input  logic        err_clear,
    output logic        m_write,
    output logic [7:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        frame_skip,
    output logic        range_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPR,
        S_OX,
        S_OY,
        S_TYPE,
        S_COMMIT
    } state_t;

    state_t state, state_n;

    logic [8:0]  id_tab [SPRITE_COUNT];
    logic [12:0] x_tab  [SPRITE_COUNT];
    logic [12:0] y_tab  [SPRITE_COUNT];

    logic [12:0] off_x_q;
    logic [12:0] off_y_q;
    // Type of the current/last upload; also serves as the "last type"
    // used to detect that every raw word must be re-encoded.
    logic [1:0]  type_q;
    logic [4:0]  cur_idx;

    logic        accept;
    logic        start;
    logic        type_chg;
    logic        spr_go;
    logic        load_spr;
    logic        found;
    logic [4:0]  sel_idx;
    logic [SPRITE_COUNT-1:0] dirty_eff;
    logic [SPRITE_COUNT-1:0] scan_mask;
    logic [SPRITE_COUNT-1:0] cand;

    logic [1:0]  enc_type;
    logic [8:0]  sel_id;
    logic [12:0] sel_x;
    logic [12:0] sel_y;
    logic [31:0] enc_word;
    logic        enc_ovf;
    logic        err_set;
    logic [12:0] ox_src;

    logic        m_write_n;
    logic [7:0]  m_address_n;
    logic [31:0] m_writedata_n;
    logic        busy_n;
    logic        done_n;

    assign accept   = m_write && !m_waitrequest;
    assign start    = (state == S_IDLE) && frame_start;
    assign type_chg = start && (cfg_world_type != type_q);
    assign spr_go   = start || ((state == S_SPR) && accept);
    assign enc_type = start ? cfg_world_type : type_q;
    assign ox_src   = start ? cfg_offset_x : off_x_q;

`ifdef SPRITE_WRITER_FULL_REFRESH_EN
    assign dirty_eff = '1;
`else
    logic [SPRITE_COUNT-1:0] dirty;
    logic [SPRITE_COUNT-1:0] dirty_n;

    assign dirty_eff = dirty | {SPRITE_COUNT{type_chg}};

    // Clear on load, then let a host write re-set the bit so a slot
    // changed during its own upload is resent next frame.
    always_comb begin
        dirty_n = dirty_eff;
        if (load_spr) begin
            dirty_n[sel_idx] = 1'b0;
        end
        if (host_we && (32'(host_index) < SPRITE_COUNT)) begin
            dirty_n[host_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty <= '1;
        end else begin
            dirty <= dirty_n;
        end
    end
`endif

    // Within an upload only slots above the one just sent are eligible,
    // so a re-dirtied slot waits for the next frame.
    always_comb begin
        scan_mask = '0;
        for (int i = 0; i < SPRITE_COUNT; i++) begin
            scan_mask[i] = (state == S_IDLE) || (5'(i) > cur_idx);
        end
    end

    assign cand = dirty_eff & scan_mask;

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = SPRITE_COUNT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found   = 1'b1;
                sel_idx = 5'(i);
            end
        end
    end

    assign sel_id = id_tab[sel_idx];
    assign sel_x  = x_tab[sel_idx];
    assign sel_y  = y_tab[sel_idx];

    always_comb begin
        enc_word = {sel_id, 23'b0};
        enc_ovf  = 1'b0;
        case (enc_type)
            2'b00: begin
                enc_word[22:10] = sel_x;
                enc_word[9:0]   = sel_y[9:0];
                enc_ovf         = |sel_y[12:10];
            end
            2'b01: begin
                enc_word[22:13] = sel_x[9:0];
                enc_word[12:0]  = sel_y;
                enc_ovf         = |sel_x[12:10];
            end
            2'b10: begin
                enc_word[22:11] = sel_x[11:0];
                enc_word[10:0]  = sel_y[10:0];
                enc_ovf         = sel_x[12] | (|sel_y[12:11]);
            end
            default: begin
                enc_ovf = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_n       = state;
        m_write_n     = m_write;
        m_address_n   = m_address;
        m_writedata_n = m_writedata;
        busy_n        = busy;
        done_n        = 1'b0;
        load_spr      = 1'b0;

        if (spr_go) begin
            m_write_n = 1'b1;
            busy_n    = 1'b1;
            if (found) begin
                state_n       = S_SPR;
                m_address_n   = {3'b0, sel_idx};
                m_writedata_n = enc_word;
                load_spr      = 1'b1;
            end else begin
                state_n       = S_OX;
                m_address_n   = 8'd32;
                m_writedata_n = {19'b0, ox_src};
            end
        end else if (accept) begin
            case (state)
                S_OX: begin
                    state_n       = S_OY;
                    m_address_n   = 8'd33;
                    m_writedata_n = {19'b0, off_y_q};
                end
                S_OY: begin
                    state_n       = S_TYPE;
                    m_address_n   = 8'd34;
                    m_writedata_n = {30'b0, type_q};
                end
                S_TYPE: begin
                    state_n       = S_COMMIT;
                    m_address_n   = 8'd35;
                    m_writedata_n = '0;
                end
                S_COMMIT: begin
                    state_n       = S_IDLE;
                    m_write_n     = 1'b0;
                    m_address_n   = '0;
                    m_writedata_n = '0;
                    busy_n        = 1'b0;
                    done_n        = 1'b1;
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    assign err_set = (start && (cfg_world_type == 2'b11))
                   | (load_spr && enc_ovf);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_skip  <= 1'b0;
            range_err   <= 1'b0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            type_q      <= 2'b00;
            cur_idx     <= '0;
        end else begin
            state       <= state_n;
            m_write     <= m_write_n;
            m_address   <= m_address_n;
            m_writedata <= m_writedata_n;
            busy        <= busy_n;
            done        <= done_n;
            frame_skip  <= frame_start && busy;
            range_err   <= err_set | (range_err & ~err_clear);
            if (start) begin
                off_x_q <= cfg_offset_x;
                off_y_q <= cfg_offset_y;
                type_q  <= cfg_world_type;
            end
            if (load_spr) begin
                cur_idx <= sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SPRITE_COUNT; i++) begin
                id_tab[i] <= '0;
                x_tab[i]  <= '0;
                y_tab[i]  <= '0;
            end
        end else if (host_we && (32'(host_index) < SPRITE_COUNT)) begin
            id_tab[host_index] <= host_id;
            x_tab[host_index]  <= host_x;
            y_tab[host_index]  <= host_y;
        end
    end

endmodule

// File: tb/tb_sprite_table_writer.sv
// Testbench for sprite_table_writer: random sprite data and world settings
// checked against a frame-level reference model of the upload sequence.

module tb_sprite_table_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_we = 1'b0;
    logic [4:0]  host_index = '0;
    logic [8:0]  host_id = '0;
    logic [12:0] host_x = '0;
    logic [12:0] host_y = '0;
    logic [12:0] cfg_offset_x = '0;
    logic [12:0] cfg_offset_y = '0;
    logic [1:0]  cfg_world_type = '0;
    logic        frame_start = 1'b0;
    logic        err_clear = 1'b0;
    logic        m_write;
    logic [7:0]  m_address;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic        frame_skip;
    logic        range_err;

    sprite_table_writer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .host_we       (host_we),
        .host_index    (host_index),
        .host_id       (host_id),
        .host_x        (host_x),
        .host_y        (host_y),
        .cfg_offset_x  (cfg_offset_x),
        .cfg_offset_y  (cfg_offset_y),
        .cfg_world_type(cfg_world_type),
        .frame_start   (frame_start),
        .err_clear     (err_clear),
        .m_write       (m_write),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .done          (done),
        .frame_skip    (frame_skip),
        .range_err     (range_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int unsigned m_id [32];
    int unsigned m_x  [32];
    int unsigned m_y  [32];
    bit          m_dirty [32];
    int          m_type;
    bit          m_err;
    logic [31:0] seen_data [256];

    function automatic void enc_model(input int unsigned id,
                                      input int unsigned x,
                                      input int unsigned y,
                                      input int t,
                                      output logic [31:0] w,
                                      output bit e);
        int unsigned v;
        v = id * 32'h0080_0000;
        e = 1'b0;
        case (t)
            0: begin
                v = v + x * 1024 + (y % 1024);
                e = (y > 1023);
            end
            1: begin
                v = v + (x % 1024) * 8192 + y;
                e = (x > 1023);
            end
            2: begin
                v = v + (x % 4096) * 2048 + (y % 2048);
                e = (x > 4095) || (y > 2047);
            end
            default: e = 1'b1;
        endcase
        w = v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int idx, input int id,
                              input int x, input int y);
        host_we    = 1'b1;
        host_index = idx[4:0];
        host_id    = id[8:0];
        host_x     = x[12:0];
        host_y     = y[12:0];
        tick();
        host_we = 1'b0;
        m_id[idx]    = id;
        m_x[idx]     = x;
        m_y[idx]     = y;
        m_dirty[idx] = 1'b1;
    endtask

    // Starts an upload in the current cycle and follows it to the done
    // pulse; returns positioned in the done cycle.
    task automatic run_frame(input int t, input int stall_addr,
                             input int stall_n, input int skip_cyc,
                             input int inflight);
        logic [7:0]  qa[$];
        logic [31:0] qd[$];
        logic [31:0] w;
        bit          e;
        int          ox;
        int          oy;
        int          c;
        int          left;
        int          done_cyc;
        bit          hit;
        int          nid;
        int          nx;
        int          ny;
        ox = $urandom_range(0, 8191);
        oy = $urandom_range(0, 8191);
        if (t != m_type) begin
            for (int i = 0; i < 32; i++) m_dirty[i] = 1'b1;
        end
        m_type = t;
        if (t == 3) m_err = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (m_dirty[i]) begin
                enc_model(m_id[i], m_x[i], m_y[i], t, w, e);
                qa.push_back(8'(i));
                qd.push_back(w);
                if (e) m_err = 1'b1;
                m_dirty[i] = 1'b0;
            end
        end
        qa.push_back(8'd32); qd.push_back(32'(ox));
        qa.push_back(8'd33); qd.push_back(32'(oy));
        qa.push_back(8'd34); qd.push_back(32'(t));
        qa.push_back(8'd35); qd.push_back(32'd0);
        done_cyc = qa.size() + 1 + ((stall_addr >= 0) ? stall_n : 0);

        cfg_offset_x   = ox[12:0];
        cfg_offset_y   = oy[12:0];
        cfg_world_type = t[1:0];
        frame_start    = 1'b1;
        tick();
        frame_start = 1'b0;
        c    = 1;
        left = stall_n;
        hit  = 1'b0;
        while (c <= 400) begin
            if (c == 1) begin
                checks++;
                if (m_write !== 1'b1 || busy !== 1'b1)
                    $display("FAIL start: m_write=%b busy=%b want 1 1",
                             m_write, busy);
                else passes++;
            end
            if (skip_cyc > 0 && c == skip_cyc + 1) begin
                checks++;
                if (frame_skip !== 1'b1)
                    $display("FAIL frame_skip: got %b want 1", frame_skip);
                else passes++;
            end
            frame_start = (skip_cyc > 0 && c == skip_cyc);
            host_we = 1'b0;
            if (qa.size() == 0) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || c != done_cyc)
                    $display("FAIL done: done=%b busy=%b cyc=%0d want 1 0 %0d",
                             done, busy, c, done_cyc);
                else passes++;
                break;
            end
            checks++;
            if (done !== 1'b0 || m_write !== 1'b1 ||
                m_address !== qa[0] || m_writedata !== qd[0])
                $display("FAIL write cyc %0d: w=%b a=%0d d=%h done=%b want a=%0d d=%h",
                         c, m_write, m_address, m_writedata, done,
                         qa[0], qd[0]);
            else passes++;
            if (32'(m_address) == stall_addr && left > 0) begin
                m_waitrequest = 1'b1;
                left--;
            end else begin
                m_waitrequest = 1'b0;
                seen_data[m_address] = m_writedata;
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (inflight >= 0 && !hit && 32'(m_address) == inflight) begin
                nid = $urandom_range(1, 511);
                nx  = $urandom_range(0, 4095);
                ny  = $urandom_range(0, 1023);
                host_we    = 1'b1;
                host_index = inflight[4:0];
                host_id    = nid[8:0];
                host_x     = nx[12:0];
                host_y     = ny[12:0];
                m_id[inflight]    = nid;
                m_x[inflight]     = nx;
                m_y[inflight]     = ny;
                m_dirty[inflight] = 1'b1;
                hit = 1'b1;
            end
            tick();
            c++;
        end
        if (c > 400) begin
            checks++;
            $display("FAIL timeout: no done within 400 cycles");
        end
        m_waitrequest = 1'b0;
        host_we       = 1'b0;
        frame_start   = 1'b0;
        checks++;
        if (range_err !== m_err)
            $display("FAIL range_err: got %b want %b", range_err, m_err);
        else passes++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            m_id[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dirty[i] = 1'b1;
        end
        m_type = 0;
        m_err  = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (m_write !== 1'b0 || m_address !== 8'd0 ||
            m_writedata !== 32'd0)
            $display("FAIL reset_bus: w=%b a=%0d d=%h want 0 0 0",
                     m_write, m_address, m_writedata);
        else passes++;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_skip !== 1'b0 ||
            range_err !== 1'b0)
            $display("FAIL reset_flags: busy=%b done=%b skip=%b err=%b want 0",
                     busy, done, frame_skip, range_err);
        else passes++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full_clear();
        run_frame(0, -1, 0, 0, -1);
        checks++;
        if (seen_data[31] !== 32'd0)
            $display("FAIL clear_slot31: got %h want 0", seen_data[31]);
        else passes++;
        tick();
    endtask

    task automatic test_single_slot();
        host_write(5, 3, 100, 50);
        run_frame(0, -1, 0, 0, -1);
        checks++;
        if (seen_data[5] !== 32'h0181_9032)
            $display("FAIL slot5_type0: got %h want 01819032", seen_data[5]);
        else passes++;
        tick();
    endtask

    task automatic test_type_change();
        run_frame(2, -1, 0, 0, -1);
        checks++;
        if (seen_data[5] !== 32'h0183_2032)
            $display("FAIL slot5_type2: got %h want 01832032", seen_data[5]);
        else passes++;
        tick();
    endtask

    task automatic test_waitrequest();
        run_frame(2, 33, 3, 0, -1);
        tick();
    endtask

    task automatic test_skip_inflight();
        host_write(3, 10, 200, 300);
        host_write(7, 11, 400, 500);
        host_write(9, 12, 600, 700);
        run_frame(2, -1, 0, 2, 7);
        tick();
        run_frame(2, -1, 0, 0, -1);
        tick();
    endtask

    task automatic test_range_err();
        host_write(1, 5, 10, 1024);
        run_frame(0, -1, 0, 0, -1);
        checks++;
        if (seen_data[1] !== 32'h0280_2800)
            $display("FAIL y_trunc: got %h want 02802800", seen_data[1]);
        else passes++;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        m_err = 1'b0;
        checks++;
        if (range_err !== 1'b0)
            $display("FAIL err_clear: got %b want 0", range_err);
        else passes++;
    endtask

    task automatic test_back_to_back();
        host_write(2, 77, 900, 800);
        run_frame(1, -1, 0, 0, -1);
        run_frame(1, 35, 2, 0, -1);
        tick();
    endtask

    task automatic test_random();
        int k;
        int t;
        int sa;
        int sn;
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(0, 5);
            for (int j = 0; j < k; j++) begin
                host_write($urandom_range(0, 31), $urandom_range(0, 511),
                           $urandom_range(0, 8191), $urandom_range(0, 8191));
            end
            t  = $urandom_range(0, 3);
            sa = ($urandom_range(0, 1) == 1) ? $urandom_range(32, 35) : -1;
            sn = $urandom_range(0, 4);
            run_frame(t, sa, sn, 0, -1);
            if ($urandom_range(0, 1) == 1) begin
                err_clear = 1'b1;
                tick();
                err_clear = 1'b0;
                m_err = 1'b0;
                checks++;
                if (range_err !== 1'b0)
                    $display("FAIL rand_err_clear: got %b want 0", range_err);
                else passes++;
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_clear();
        test_single_slot();
        test_type_change();
        test_waitrequest();
        test_skip_inflight();
        test_range_err();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
